// File: rtl/encode_sib_stream_if.sv
// rtl/encode_sib_stream_if.sv - request and encoded byte-stream bundle for encode_sib_stream
interface encode_sib_stream_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_reg_field;
    logic        req_base_used;
    logic [2:0]  req_base_index;
    logic        req_index_used;
    logic [2:0]  req_index_index;
    logic [1:0]  req_scale;
    logic [31:0] req_displacement;
    logic        req_error;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [1:0]  out_kind;
    logic        out_last;

    modport slave (
        input  req_valid, req_reg_field, req_base_used, req_base_index,
               req_index_used, req_index_index, req_scale, req_displacement,
               out_ready,
        output req_ready, req_error, out_valid, out_byte, out_kind, out_last
    );

    modport master (
        output req_valid, req_reg_field, req_base_used, req_base_index,
               req_index_used, req_index_index, req_scale, req_displacement,
               out_ready,
        input  req_ready, req_error, out_valid, out_byte, out_kind, out_last
    );
endinterface

// File: rtl/encode_sib_stream.sv
// rtl/encode_sib_stream.sv - ModR/M, SIB and displacement byte-stream encoder
// Option W80386_SIB_ENC_SHORT_DISP_EN enables disp0/disp8 compression.
module encode_sib_stream #(
    parameter bit SIB_ALWAYS = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    encode_sib_stream_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MODRM, SIB, DISP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  modrm_q, sib_q;
    logic        need_sib_q, has_disp_q;
    logic [31:0] disp_q;
    logic [1:0]  disp_left;
    logic        req_error_q;

    logic        accept, reject, need_sib, has_disp, handshake;
    logic [1:0]  mode, disp_init;
    logic [2:0]  rm;
    logic [7:0]  modrm_c, sib_c;
    logic        out_valid_c, out_last_c;
    logic [7:0]  out_byte_c;
    logic [1:0]  out_kind_c;

    assign accept   = bus.req_valid & (state == IDLE);
    assign reject   = bus.req_index_used & (bus.req_index_index == 3'd4);
    assign need_sib = bus.req_index_used
                    | (bus.req_base_used & (bus.req_base_index == 3'd4))
                    | SIB_ALWAYS;

`ifdef W80386_SIB_ENC_SHORT_DISP_EN
    logic disp_fits8;
    assign disp_fits8 = (&bus.req_displacement[31:7]) | ~(|bus.req_displacement[31:7]);
`endif

    // EBP as base cannot use mod=00: that slot means "no base, disp32".
    always_comb begin
        mode      = 2'b10;
        has_disp  = 1'b1;
        disp_init = 2'd3;
        if (!bus.req_base_used) begin
            mode = 2'b00;
        end
`ifdef W80386_SIB_ENC_SHORT_DISP_EN
        else if ((bus.req_displacement == 32'd0) && (bus.req_base_index != 3'd5)) begin
            mode      = 2'b00;
            has_disp  = 1'b0;
            disp_init = 2'd0;
        end else if (disp_fits8) begin
            mode      = 2'b01;
            disp_init = 2'd0;
        end
`endif
    end

    assign rm      = need_sib ? 3'd4 : (bus.req_base_used ? bus.req_base_index : 3'd5);
    assign modrm_c = {mode, bus.req_reg_field, rm};
    assign sib_c   = {bus.req_index_used ? bus.req_scale : 2'b00,
                      bus.req_index_used ? bus.req_index_index : 3'd4,
                      bus.req_base_used ? bus.req_base_index : 3'd5};

    assign handshake = out_valid_c & bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            modrm_q     <= 8'd0;
            sib_q       <= 8'd0;
            need_sib_q  <= 1'b0;
            has_disp_q  <= 1'b0;
            disp_q      <= 32'd0;
            disp_left   <= 2'd0;
            req_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_error_q <= accept & reject;
            if (accept & !reject) begin
                modrm_q    <= modrm_c;
                sib_q      <= sib_c;
                need_sib_q <= need_sib;
                has_disp_q <= has_disp;
                disp_q     <= bus.req_displacement;
                disp_left  <= disp_init;
            end else if ((state == DISP) && handshake) begin
                disp_q    <= disp_q >> 8;
                disp_left <= disp_left - 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        out_valid_c = 1'b0;
        out_byte_c  = 8'd0;
        out_kind_c  = 2'd0;
        out_last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reject) state_nxt = MODRM;
            end
            MODRM: begin
                out_valid_c = 1'b1;
                out_byte_c  = modrm_q;
                out_kind_c  = 2'd0;
                out_last_c  = !need_sib_q && !has_disp_q;
                if (bus.out_ready)
                    state_nxt = need_sib_q ? SIB : (has_disp_q ? DISP : IDLE);
            end
            SIB: begin
                out_valid_c = 1'b1;
                out_byte_c  = sib_q;
                out_kind_c  = 2'd1;
                out_last_c  = !has_disp_q;
                if (bus.out_ready)
                    state_nxt = has_disp_q ? DISP : IDLE;
            end
            DISP: begin
                out_valid_c = 1'b1;
                out_byte_c  = disp_q[7:0];
                out_kind_c  = 2'd2;
                out_last_c  = (disp_left == 2'd0);
                if (bus.out_ready && (disp_left == 2'd0))
                    state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.req_error = req_error_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_byte  = out_byte_c;
    assign bus.out_kind  = out_kind_c;
    assign bus.out_last  = out_last_c;
endmodule

// File: tb/tb_encode_sib_stream.sv
// tb/tb_encode_sib_stream.sv - self-checking bench for encode_sib_stream (default and SIB_ALWAYS=1 instances)
module tb_encode_sib_stream;
    typedef struct packed {
        logic [2:0]  reg_field;
        logic        bu;
        logic [2:0]  bi;
        logic        iu;
        logic [2:0]  ii;
        logic [1:0]  sc;
        logic [31:0] disp;
    } req_t;

    typedef struct packed {
        int          n;
        logic [47:0] b;
        logic [11:0] k;
        logic [5:0]  l;
    } seq_t;

    typedef struct {
        string       name;
        req_t        r;
        int          na;
        logic [47:0] ea;
        int          nb;
        logic [47:0] eb;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   checks, failures;
    vec_t vt[8];

    always #5 clock = ~clock;

    encode_sib_stream_if ifa();
    encode_sib_stream_if ifb();

    assign ifb.req_valid        = ifa.req_valid;
    assign ifb.req_reg_field    = ifa.req_reg_field;
    assign ifb.req_base_used    = ifa.req_base_used;
    assign ifb.req_base_index   = ifa.req_base_index;
    assign ifb.req_index_used   = ifa.req_index_used;
    assign ifb.req_index_index  = ifa.req_index_index;
    assign ifb.req_scale        = ifa.req_scale;
    assign ifb.req_displacement = ifa.req_displacement;
    assign ifb.out_ready        = ifa.out_ready;

    encode_sib_stream #(.SIB_ALWAYS(1'b0)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa.slave));
    encode_sib_stream #(.SIB_ALWAYS(1'b1)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb.slave));

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [2:0] rf, input logic bu, input logic [2:0] bi,
                                input logic iu, input logic [2:0] ii, input logic [1:0] sc,
                                input logic [31:0] d);
        req_t r;
        r.reg_field = rf; r.bu = bu; r.bi = bi; r.iu = iu; r.ii = ii; r.sc = sc; r.disp = d;
        return r;
    endfunction

    // Encoding rules from the operand description, using signed arithmetic for ranges.
    function automatic seq_t model(input req_t r, input bit sib_always);
        seq_t       e;
        int         d, dl;
        logic [1:0] md;
        logic [2:0] rmf;
        bit         sib;
        d   = $signed(r.disp);
        sib = r.iu || (r.bu && r.bi == 3'd4) || sib_always;
        if (!r.bu) begin md = 2'd0; dl = 4; end
`ifdef W80386_SIB_ENC_SHORT_DISP_EN
        else if (d == 0 && r.bi != 3'd5) begin md = 2'd0; dl = 0; end
        else if (d >= -128 && d <= 127) begin md = 2'd1; dl = 1; end
`endif
        else begin md = 2'd2; dl = 4; end
        rmf = sib ? 3'd4 : (r.bu ? r.bi : 3'd5);
        e = '0;
        e.b[7:0] = {md, r.reg_field, rmf};
        e.n = 1;
        if (sib) begin
            e.b[8*e.n +: 8] = {r.iu ? r.sc : 2'd0, r.iu ? r.ii : 3'd4, r.bu ? r.bi : 3'd5};
            e.k[2*e.n +: 2] = 2'd1;
            e.n++;
        end
        for (int i = 0; i < dl; i++) begin
            e.b[8*e.n +: 8] = 8'(r.disp >> (8*i));
            e.k[2*e.n +: 2] = 2'd2;
            e.n++;
        end
        e.l = 6'(1 << (e.n - 1));
        return e;
    endfunction

    task automatic check_seq(input string nm, input seq_t g, input seq_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got n=%0d bytes=%h kinds=%h last=%b exp n=%0d bytes=%h kinds=%h last=%b",
                     nm, g.n, g.b, g.k, g.l, e.n, e.b, e.k, e.l);
        end
    endtask

    task automatic observe(input string nm, input logic v, input logic rdy, input logic [7:0] b,
                           input logic [1:0] k, input logic l,
                           inout seq_t g, inout logic [11:0] prev, inout bit done);
        if (prev[11]) chk({nm, "_stall_hold"}, {v, b, k, l}, {1'b1, prev[10:0]});
        prev = {v & !rdy, b, k, l};
        if (!done && v && rdy) begin
            if (g.n < 6) begin
                g.b[8*g.n +: 8] = b;
                g.k[2*g.n +: 2] = k;
                g.l[g.n]        = l;
            end
            g.n++;
            if (l) done = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ifa.req_valid = 1'b0;
        ifa.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic drive_req(input req_t r);
        ifa.req_reg_field    = r.reg_field;
        ifa.req_base_used    = r.bu;
        ifa.req_base_index   = r.bi;
        ifa.req_index_used   = r.iu;
        ifa.req_index_index  = r.ii;
        ifa.req_scale        = r.sc;
        ifa.req_displacement = r.disp;
        ifa.req_valid        = 1'b1;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on the second byte of dut_a
    task automatic run_req(input req_t r, input int mode, output seq_t ga, output seq_t gb, output int held);
        bit          da, db, ok;
        logic [11:0] pa, pb;
        int          stall;
        ga = '0; gb = '0; da = 0; db = 0; ok = 0; pa = '0; pb = '0; stall = 0; held = 0;
        chk("ready_before", {ifa.req_ready, ifb.req_ready}, 2'b11);
        drive_req(r);
        ifa.out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ifa.req_valid = 1'b0;
        chk("latency_valid", {ifa.out_valid, ifb.out_valid}, 2'b11);
        for (int c = 0; c < 80; c++) begin
            if (mode == 0) ifa.out_ready = 1'b1;
            else if (mode == 1) ifa.out_ready = ($urandom_range(0, 3) != 0);
            else if (ga.n == 1 && stall < 3) begin ifa.out_ready = 1'b0; stall++; end
            else ifa.out_ready = 1'b1;
            #1;
            if (ifa.out_valid && !ifa.out_ready && ifa.out_byte == 8'h78) held++;
            observe("a", ifa.out_valid, ifa.out_ready, ifa.out_byte, ifa.out_kind, ifa.out_last, ga, pa, da);
            observe("b", ifb.out_valid, ifb.out_ready, ifb.out_byte, ifb.out_kind, ifb.out_last, gb, pb, db);
            if (da && db) begin ok = 1; break; end
            @(negedge clock);
        end
        @(negedge clock);
        ifa.out_ready = 1'b0;
        chk("sequence_done", {63'd0, ok}, 64'd1);
        if (ok) chk("ready_after", {ifa.req_ready, ifb.req_ready}, 2'b11);
        else do_reset();
    endtask

    task automatic set_vec(input int i, input string nm, input req_t r, input int na, input logic [47:0] ea,
                           input int nb, input logic [47:0] eb);
        vt[i].name = nm; vt[i].r = r; vt[i].na = na; vt[i].ea = ea; vt[i].nb = nb; vt[i].eb = eb;
    endtask

    initial begin
        seq_t ga, gb, ea, eb;
        req_t r;
        int   held;
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        ifa.req_valid = 1'b0;
        ifa.out_ready = 1'b0;
        drive_req(mk(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 32'd0));
        ifa.req_valid = 1'b0;

`ifdef W80386_SIB_ENC_SHORT_DISP_EN
        set_vec(0, "eax_ecx4", mk(3'd2, 1'b1, 3'd0, 1'b1, 3'd1, 2'd2, 32'd0), 2, 48'h8814, 2, 48'h8814);
        set_vec(1, "ebp_10", mk(3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 2'd0, 32'h10), 2, 48'h1045, 3, 48'h102544);
        set_vec(2, "ebp_0", mk(3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 2'd0, 32'h0), 2, 48'h0045, 3, 48'h002544);
        set_vec(3, "esp", mk(3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 2'd0, 32'h0), 2, 48'h2404, 2, 48'h2404);
        set_vec(6, "eax_m2", mk(3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFE), 2, 48'hFE78, 3, 48'hFE207C);
`else
        set_vec(0, "eax_ecx4", mk(3'd2, 1'b1, 3'd0, 1'b1, 3'd1, 2'd2, 32'd0), 6, 48'h8894, 6, 48'h8894);
        set_vec(1, "ebp_10", mk(3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 2'd0, 32'h10), 5, 48'h1085, 6, 48'h102584);
        set_vec(2, "ebp_0", mk(3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 2'd0, 32'h0), 5, 48'h0085, 6, 48'h002584);
        set_vec(3, "esp", mk(3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 2'd0, 32'h0), 6, 48'h2484, 6, 48'h2484);
        set_vec(6, "eax_m2", mk(3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFE), 5, 48'hFFFF_FFFE_B8, 6, 48'hFFFF_FFFE_20BC);
`endif
        set_vec(4, "ecx2_100", mk(3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 2'd1, 32'h100), 6, 48'h0000_0100_4D04, 6, 48'h0000_0100_4D04);
        set_vec(5, "disp32", mk(3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 32'h1234_5678), 5, 48'h12_3456_781D, 6, 48'h1234_5678_251C);
        set_vec(7, "edx_80", mk(3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 2'd0, 32'h80), 5, 48'h80_82, 6, 48'h80_2284);

        repeat (3) @(negedge clock);
        chk("reset_a", {ifa.out_valid, ifa.out_byte, ifa.out_kind, ifa.out_last, ifa.req_error, ifa.req_ready}, 14'h1);
        chk("reset_b", {ifb.out_valid, ifb.out_byte, ifb.out_kind, ifb.out_last, ifb.req_error, ifb.req_ready}, 14'h1);
        reset_n = 1'b1;
        @(negedge clock);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                run_req(vt[i].r, m, ga, gb, held);
                ea = model(vt[i].r, 1'b0);
                eb = model(vt[i].r, 1'b1);
                ea.n = vt[i].na; ea.b = vt[i].ea; ea.l = 6'(1 << (vt[i].na - 1));
                eb.n = vt[i].nb; eb.b = vt[i].eb; eb.l = 6'(1 << (vt[i].nb - 1));
                check_seq({vt[i].name, "_a"}, ga, ea);
                check_seq({vt[i].name, "_b"}, gb, eb);
            end
        end

        // Rejected request: one error pulse, no bytes, still ready.
        drive_req(mk(3'd1, 1'b1, 3'd0, 1'b1, 3'd4, 2'd3, 32'h5));
        @(posedge clock);
        @(negedge clock);
        ifa.req_valid = 1'b0;
        ifa.out_ready = 1'b1;
        chk("reject_pulse", {ifa.req_error, ifa.out_valid, ifb.req_error, ifb.out_valid}, 4'b1010);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("reject_after", {ifa.req_error, ifa.out_valid, ifa.req_ready, ifb.req_error, ifb.out_valid, ifb.req_ready},
                6'b001001);
        end
        ifa.out_ready = 1'b0;

        // Backpressure on the first displacement byte of the disp32-only case.
        run_req(vt[5].r, 2, ga, gb, held);
        chk("held_78_cycles", 64'(held), 64'd3);
        check_seq("stall_a", ga, model(vt[5].r, 1'b0));
        check_seq("stall_b", gb, model(vt[5].r, 1'b1));

        // Reset in the middle of the displacement bytes.
        drive_req(vt[5].r);
        @(posedge clock);
        @(negedge clock);
        ifa.req_valid = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("pre_reset_valid", {ifa.out_valid, ifa.out_kind, ifb.out_valid, ifb.out_kind}, 6'b110_110);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_abort", {ifa.out_valid, ifb.out_valid, ifa.req_ready, ifb.req_ready}, 4'b0011);
        @(negedge clock);
        ifa.out_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", {ifa.out_valid, ifb.out_valid}, 2'b00);
        run_req(vt[5].r, 0, ga, gb, held);
        check_seq("after_reset_a", ga, model(vt[5].r, 1'b0));
        check_seq("after_reset_b", gb, model(vt[5].r, 1'b1));

        // Randomized operands against the reference model.
        for (int t = 0; t < 60; t++) begin
            r.reg_field = 3'($urandom);
            r.bu        = 1'($urandom);
            r.bi        = 3'($urandom);
            r.iu        = 1'($urandom);
            r.ii        = 3'($urandom);
            if (r.iu && r.ii == 3'd4) r.ii = 3'($urandom_range(5, 7));
            r.sc        = 2'($urandom);
            case ($urandom_range(0, 3))
                0: r.disp = 32'd0;
                1: r.disp = 32'(int'($urandom_range(0, 255)) - 128);
                2: case ($urandom_range(0, 3))
                       0: r.disp = 32'd127;
                       1: r.disp = 32'd128;
                       2: r.disp = 32'hFFFF_FF80;
                       default: r.disp = 32'hFFFF_FF7F;
                   endcase
                default: r.disp = $urandom;
            endcase
            run_req(r, int'($urandom_range(0, 1)), ga, gb, held);
            check_seq($sformatf("rand%0d_a", t), ga, model(r, 1'b0));
            check_seq($sformatf("rand%0d_b", t), gb, model(r, 1'b1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
